// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem handshake, stall hold buffer,
// redirect handling and the IF/ID register. Macro BRANCH_DELAY_SLOT_EN keeps the delay-slot word.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [31:0]          instrD,
  output logic [31:0]          pcD,
  output logic [31:0]          pc_plus4D,
  output logic                 validD
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc_d_reg, pc_d_next;
  logic [31:0] pc_plus4_d_reg, pc_plus4_d_next;
  logic        valid_reg, valid_next;
  logic        pend_valid_reg, pend_valid_next;
  logic [31:0] pend_pc_reg, pend_pc_next;
  logic [31:0] hold_word_reg, hold_word_next;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        redirect_take;
  logic        deliver;
  logic        slot_word;
  logic [31:0] deliver_word;

  assign pc_plus4        = pc_reg + 32'd4;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign redirect_take   = redirect && !stall;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    instr_next      = instr_reg;
    pc_d_next       = pc_d_reg;
    pc_plus4_d_next = pc_plus4_d_reg;
    valid_next      = valid_reg;
    pend_valid_next = pend_valid_reg;
    pend_pc_next    = pend_pc_reg;
    hold_word_next  = hold_word_reg;
    deliver         = 1'b0;
    deliver_word    = 32'h0;
    slot_word       = 1'b0;

    unique case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (imem.imem_ack) begin
          if (stall) begin
            hold_word_next = imem.imem_rdata;
            state_next     = HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_word = imem.imem_rdata;
          end
        end else if (!stall) begin
          // Request still outstanding: bubble, and park any redirect until the ack.
          valid_next = 1'b0;
          instr_next = 32'h0;
          if (redirect_take) begin
            pend_valid_next = 1'b1;
            pend_pc_next    = redirect_target;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          deliver      = 1'b1;
          deliver_word = hold_word_reg;
          state_next   = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase

    if (deliver) begin
      // The word delivered alongside (or after) an accepted redirect is the delay slot.
      slot_word       = redirect_take || pend_valid_reg;
      pc_d_next       = pc_reg;
      pc_plus4_d_next = pc_plus4;
      instr_next      = deliver_word;
      valid_next      = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
`else
      if (slot_word) begin
        instr_next = 32'h0;
        valid_next = 1'b0;
      end
`endif
      if (redirect_take)       pc_next = redirect_target;
      else if (pend_valid_reg) pc_next = pend_pc_reg;
      else                     pc_next = pc_plus4;
      pend_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      instr_reg      <= 32'h0;
      pc_d_reg       <= 32'h0;
      pc_plus4_d_reg <= 32'h0;
      valid_reg      <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_pc_reg    <= 32'h0;
      hold_word_reg  <= 32'h0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      instr_reg      <= instr_next;
      pc_d_reg       <= pc_d_next;
      pc_plus4_d_reg <= pc_plus4_d_next;
      valid_reg      <= valid_next;
      pend_valid_reg <= pend_valid_next;
      pend_pc_reg    <= pend_pc_next;
      hold_word_reg  <= hold_word_next;
    end
  end

  assign imem.imem_req  = (state_reg == FETCH);
  assign imem.imem_addr = pc_reg;
  assign instrD         = instr_reg;
  assign pcD            = pc_d_reg;
  assign pc_plus4D      = pc_plus4_d_reg;
  assign validD         = valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addr ^ 32'h5A00_0000 as the
// instruction word; inputs change and outputs are checked on the falling edge.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instrD, pcD, pc_plus4D;
  logic        validD;
  int          vectors = 0;
  int          miscompares = 0;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .instrD      (instrD),
    .pcD         (pcD),
    .pc_plus4D   (pc_plus4D),
    .validD      (validD)
  );

  always #5 clk = ~clk;

  assign imem.imem_rdata = imem.imem_addr ^ 32'h5A00_0000;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic SLOT_VALID = 1'b1;
  localparam logic SLOT_KEEP  = 1'b1;
`else
  localparam logic SLOT_VALID = 1'b0;
  localparam logic SLOT_KEEP  = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rpc, input logic a);
    stall             = s;
    redirect          = r;
    redirect_pc       = rpc;
    imem.imem_ack     = a;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'h0, validD}, 32'h0);
    chk("rst_instr", instrD, 32'h0);
    chk("rst_pcD", pcD, 32'h0);
    chk("rst_pc4D", pc_plus4D, 32'h0);
    chk("rst_req", {31'h0, imem.imem_req}, 32'h0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1);

    @(negedge clk);
    chk("f0_req", {31'h0, imem.imem_req}, 32'h1);
    chk("f0_addr", imem.imem_addr, 32'h0000_3000);

    @(negedge clk);
    chk("f1_addr", imem.imem_addr, 32'h0000_3004);
    chk("f1_valid", {31'h0, validD}, 32'h1);
    chk("f1_pcD", pcD, 32'h0000_3000);
    chk("f1_pc4D", pc_plus4D, 32'h0000_3004);
    chk("f1_instr", instrD, 32'h5A00_3000);

    @(negedge clk);
    chk("f2_addr", imem.imem_addr, 32'h0000_3008);
    chk("f2_pcD", pcD, 32'h0000_3004);
    drive(1'b1, 1'b0, 32'h0, 1'b1);

    @(negedge clk);
    chk("hold_req", {31'h0, imem.imem_req}, 32'h0);
    chk("hold_pcD", pcD, 32'h0000_3004);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("hold2_req", {31'h0, imem.imem_req}, 32'h0);
    chk("hold2_instr", instrD, 32'h5A00_3004);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    @(negedge clk);
    chk("rel_instr", instrD, 32'h5A00_3008);
    chk("rel_pcD", pcD, 32'h0000_3008);
    chk("rel_addr", imem.imem_addr, 32'h0000_300C);
    chk("rel_req", {31'h0, imem.imem_req}, 32'h1);
    drive(1'b0, 1'b1, 32'h0000_3100, 1'b1);

    @(negedge clk);
    chk("redir_addr", imem.imem_addr, 32'h0000_3100);
    chk("redir_pcD", pcD, 32'h0000_300C);
    chk("redir_slot_valid", {31'h0, validD}, {31'h0, SLOT_VALID});
    chk("redir_slot_instr", instrD, SLOT_KEEP ? 32'h5A00_300C : 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);

    @(negedge clk);
    chk("tgt_valid", {31'h0, validD}, 32'h1);
    chk("tgt_instr", instrD, 32'h5A00_3100);
    chk("tgt_next_addr", imem.imem_addr, 32'h0000_3104);
    drive(1'b0, 1'b1, 32'h0000_3200, 1'b0);

    @(negedge clk);
    chk("bubble_valid", {31'h0, validD}, 32'h0);
    chk("bubble_instr", instrD, 32'h0);
    chk("pend_addr0", imem.imem_addr, 32'h0000_3104);
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    @(negedge clk);
    chk("pend_addr1", imem.imem_addr, 32'h0000_3104);
    drive(1'b0, 1'b1, 32'h0000_3303, 1'b0);

    @(negedge clk);
    chk("pend_addr2", imem.imem_addr, 32'h0000_3104);
    drive(1'b0, 1'b0, 32'h0, 1'b1);

    @(negedge clk);
    chk("pend_new_addr", imem.imem_addr, 32'h0000_3300);
    chk("pend_slot_pcD", pcD, 32'h0000_3104);
    chk("pend_slot_valid", {31'h0, validD}, {31'h0, SLOT_VALID});
    drive(1'b0, 1'b0, 32'h0, 1'b1);

    @(negedge clk);
    chk("pend_tgt_pcD", pcD, 32'h0000_3300);
    chk("pend_tgt_valid", {31'h0, validD}, 32'h1);
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);

    @(negedge clk);
    chk("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b1);

    @(negedge clk);
    chk("wrap_pcD", pcD, 32'hFFFF_FFFC);
    chk("wrap_pc4D", pc_plus4D, 32'h0000_0000);
    chk("wrap_instr", instrD, 32'hA5FF_FFFC);
    chk("wrap_next_addr", imem.imem_addr, 32'h0000_0000);
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1);

    @(negedge clk);
    chk("mid_rst_valid", {31'h0, validD}, 32'h0);
    chk("mid_rst_instr", instrD, 32'h0);
    chk("mid_rst_req", {31'h0, imem.imem_req}, 32'h0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    @(negedge clk);
    chk("post_rst_addr", imem.imem_addr, 32'h0000_3000);
    chk("post_rst_valid", {31'h0, validD}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);

    @(negedge clk);
    chk("post_rst_pcD", pcD, 32'h0000_3000);
    chk("post_rst_instr", instrD, 32'h5A00_3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
